ace_ac_ingress: RTL and testbench
=================================

// Module: ace_ac_ingress
// PURPOSE
//  Ingress stage on the ACE snoop-address (AC) channel, directly upstream of the devil core.
//  Accepts snoops from the interconnect, classifies each against the ACSNOOP and address-window
//  filters (CTRL.ACFLT / CTRL.ADDRFLT, ACSNOOP, BASE_ADDR, MEM_SIZE registers), and forwards every
//  snoop with a match flag. The core acts only on match=1 snoops but still answers CR for all of them.
//  Registered acready and a 2-entry skid buffer give full throughput without a comb path to the core.
// PARAMETERS
//  ADDR_W   44  AC address width
//  SNOOP_W  4   ACSNOOP width
//  CNT_W    32  statistics counter width
// PORTS
//  ace_aclk        in   1        single clock
//  ace_aresetn     in   1        reset, asynchronous assert, active-low
//  acvalid         in   1        AC valid from interconnect
//  acready         out  1        AC ready (registered)
//  acaddr          in   ADDR_W   snoop address
//  acsnoop         in   SNOOP_W  snoop type
//  acprot          in   3        snoop protection, forwarded unchanged
//  cfg_en          in   1        CTRL.EN
//  cfg_acflt_en    in   1        CTRL.ACFLT
//  cfg_addrflt_en  in   1        CTRL.ADDRFLT
//  cfg_acsnoop     in   SNOOP_W  ACSNOOP register
//  cfg_base_addr   in   32       BASE_ADDR register
//  cfg_mem_size    in   32       MEM_SIZE register, bytes
//  stat_clr        in   1        pulse: clear both counters
//  m_valid         out  1        classified snoop to core
//  m_ready         in   1        core accepts
//  m_addr          out  ADDR_W   forwarded acaddr
//  m_snoop         out  SNOOP_W  forwarded acsnoop
//  m_prot          out  3        forwarded acprot
//  m_match         out  1        1 = core must act on this snoop
//  stat_snoop_cnt  out  CNT_W    AC handshakes seen
//  stat_match_cnt  out  CNT_W    handshakes with match=1
// BEHAVIOUR
//  - Reset: acready=0, m_valid=0, m_addr/m_snoop/m_prot/m_match=0, counters=0, state EMPTY.
//    acready rises in the first cycle after ace_aresetn deasserts.
//  - Classification at AC handshake (acvalid&acready), cfg sampled in that cycle:
//    snoop_ok = !cfg_acflt_en | (acsnoop == cfg_acsnoop)
//    addr_ok  = !cfg_addrflt_en | (acaddr >= base && acaddr < base+size); base zero-extended to
//               ADDR_W, sum computed at ADDR_W+1 bits (no wrap); size==0 -> addr_ok=0 when enabled
//    match    = cfg_en & snoop_ok & addr_ok; the result is stored with the entry, so later cfg
//               changes do not alter buffered entries.
//  - Latency: empty buffer, handshake in cycle N -> m_valid=1 in N+1 with that entry.
//  - Output stable: while m_valid & !m_ready, all m_* held unchanged.
//  - Skid FSM (entry count): EMPTY -> ONE on in-hs; ONE -> FULL on in-hs & !out-hs;
//    ONE -> EMPTY on out-hs & !in-hs; ONE stays on both; FULL -> ONE on out-hs.
//    acready = (state != FULL), registered from next-state. In FULL, no in-hs possible.
//  - Ordering strictly FIFO; entries never dropped, merged or reordered.
//  - Counters: +1 per AC handshake (match counter only if match=1), saturate at all-ones.
//    stat_clr wins over a simultaneous increment (result 0).
//  - cfg_en=0: snoops still accepted and forwarded with m_match=0 (the interconnect must never stall).
//  - Reset mid-operation: buffered entries discarded, outputs to reset values immediately (async).
// STRUCTURE
//  - Shared package devil_pkg: ADDR_W/SNOOP_W constants, ac_entry_t {addr, snoop, prot, match},
//    skid state enum {EMPTY, ONE, FULL}, ACSNOOP encodings (READ_ONCE=4'b0000 etc.).
//  - One sub-module: ace_skid_buf (2-entry ready/valid buffer on ac_entry_t).
//    Classifier and counters stay in the top.
// TESTING
//  - Reset: hold ace_aresetn=0 16 cycles -> acready=0, m_valid=0, counters=0; acready=1 1 cycle after release.
//  - Filters off, cfg_en=1, snoop addr 0x2 -> m_valid next cycle, m_addr=0x2, m_match=1, both counters=1.
//  - ACFLT=1, cfg_acsnoop=1: send acsnoop 0 then 1 -> m_match 0 then 1; match count 1, snoop count 2.
//  - ADDRFLT=1, base 0x10, size 0x100: addrs 0xF, 0x10, 0x10F, 0x110 -> m_match 0,1,1,0;
//    size=0 -> all 0.
//  - Backpressure: m_ready=0, 3 back-to-back snoops -> 2 accepted, acready=0 in FULL,
//    m_* stable; release m_ready -> 3 delivered in order.
//  - Counters preset near all-ones -> saturate; stat_clr with a simultaneous handshake -> 0;
//    reset asserted while FULL -> buffer empty.

Source files
------------

// File: rtl/devil_pkg.sv
// Shared definitions for the devil-core ACE snoop-address (AC) ingress path.
//   ADDR_W / SNOOP_W  : AC channel field widths
//   ac_entry_t        : one classified snoop as held in the skid buffer
//   skid_state_e      : skid-buffer occupancy state
//   Acsnoop*          : ACSNOOP encodings
package devil_pkg;

    localparam int unsigned ADDR_W     = 44;
    localparam int unsigned SNOOP_W    = 4;
    localparam int unsigned AC_ENTRY_W = ADDR_W + SNOOP_W + 3 + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [SNOOP_W-1:0] snoop;
        logic [2:0]         prot;
        logic               match;
    } ac_entry_t;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

    localparam logic [SNOOP_W-1:0] AcsnoopReadOnce          = 4'b0000;
    localparam logic [SNOOP_W-1:0] AcsnoopReadShared        = 4'b0001;
    localparam logic [SNOOP_W-1:0] AcsnoopReadClean         = 4'b0010;
    localparam logic [SNOOP_W-1:0] AcsnoopReadNotSharedDirty = 4'b0011;
    localparam logic [SNOOP_W-1:0] AcsnoopReadUnique        = 4'b0111;
    localparam logic [SNOOP_W-1:0] AcsnoopCleanShared       = 4'b1000;
    localparam logic [SNOOP_W-1:0] AcsnoopCleanInvalid      = 4'b1001;
    localparam logic [SNOOP_W-1:0] AcsnoopMakeInvalid       = 4'b1101;
    localparam logic [SNOOP_W-1:0] AcsnoopDvmComplete       = 4'b1110;
    localparam logic [SNOOP_W-1:0] AcsnoopDvmMessage        = 4'b1111;

endpackage

// File: rtl/ace_skid_buf.sv
// Two-entry ready/valid skid buffer for classified AC snoops.
// o_ready is a register, so there is no combinational path from i_ready back to the
// upstream ready; two entries keep full throughput despite that.
//   i_clk, i_rst_n    : clock, asynchronous active-low reset
//   i_valid/o_ready   : upstream handshake, i_data entry
//   o_valid/i_ready   : downstream handshake, o_data entry (held while stalled)
module ace_skid_buf
    import devil_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [AC_ENTRY_W-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [AC_ENTRY_W-1:0] o_data
);

    skid_state_e           r_state;
    skid_state_e           w_state_d;
    logic [AC_ENTRY_W-1:0] r_head;
    logic [AC_ENTRY_W-1:0] r_skid;
    logic                  r_ready;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_load_head;
    logic                  w_head_from_skid;
    logic                  w_load_skid;

    assign w_in_hs  = i_valid & r_ready;
    assign w_out_hs = (r_state != StEmpty) & i_ready;

    always_comb begin
        w_state_d        = r_state;
        w_load_head      = 1'b0;
        w_head_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            StEmpty: begin
                if (w_in_hs) begin
                    w_state_d   = StOne;
                    w_load_head = 1'b1;
                end
            end
            StOne: begin
                if (w_in_hs && !w_out_hs) begin
                    w_state_d   = StFull;
                    w_load_skid = 1'b1;
                end else if (w_out_hs && !w_in_hs) begin
                    w_state_d = StEmpty;
                end else if (w_in_hs && w_out_hs) begin
                    w_load_head = 1'b1;
                end
            end
            StFull: begin
                if (w_out_hs) begin
                    w_state_d        = StOne;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_d = StEmpty;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StEmpty;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            // Ready looks ahead at next occupancy so it is a plain flop output.
            r_ready <= (w_state_d != StFull);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head) begin
                r_head <= i_data;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_state != StEmpty);
    assign o_data  = r_head;

endmodule

// File: rtl/ace_ac_ingress.sv
// AC-channel ingress ahead of the devil core. Every accepted snoop is classified against
// the ACSNOOP and address-window filters and forwarded, in order, with a match flag; the
// core still answers CR for non-matching snoops, so nothing is ever dropped.
//   ace_aclk, ace_aresetn       : clock, asynchronous active-low reset
//   acvalid/acready, ac*        : AC channel from the interconnect
//   cfg_*                       : CTRL / ACSNOOP / BASE_ADDR / MEM_SIZE register values
//   stat_clr                    : clears both statistics counters
//   m_valid/m_ready, m_*        : classified snoop to the core
//   stat_snoop_cnt/match_cnt    : saturating handshake / match counters
module ace_ac_ingress
    import devil_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               ace_aclk,
    input  logic               ace_aresetn,
    input  logic               acvalid,
    output logic               acready,
    input  logic [ADDR_W-1:0]  acaddr,
    input  logic [SNOOP_W-1:0] acsnoop,
    input  logic [2:0]         acprot,
    input  logic               cfg_en,
    input  logic               cfg_acflt_en,
    input  logic               cfg_addrflt_en,
    input  logic [SNOOP_W-1:0] cfg_acsnoop,
    input  logic [31:0]        cfg_base_addr,
    input  logic [31:0]        cfg_mem_size,
    input  logic               stat_clr,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [SNOOP_W-1:0] m_snoop,
    output logic [2:0]         m_prot,
    output logic               m_match,
    output logic [CNT_W-1:0]   stat_snoop_cnt,
    output logic [CNT_W-1:0]   stat_match_cnt
);

    logic              w_ac_hs;
    logic [ADDR_W-1:0] w_base_ext;
    logic [ADDR_W:0]   w_limit;
    logic              w_snoop_ok;
    logic              w_addr_ok;
    logic              w_match;
    ac_entry_t         w_in_entry;
    ac_entry_t         w_out_entry;
    logic [CNT_W-1:0]  r_snoop_cnt;
    logic [CNT_W-1:0]  r_match_cnt;

    assign w_ac_hs = acvalid & acready;

    // Window end is one bit wider so base+size past the top of the address space cannot
    // wrap; size==0 gives limit==base and thus an empty window.
    assign w_base_ext = {{(ADDR_W - 32){1'b0}}, cfg_base_addr};
    assign w_limit    = {1'b0, w_base_ext} + {{(ADDR_W - 31){1'b0}}, cfg_mem_size};
    assign w_snoop_ok = !cfg_acflt_en || (acsnoop == cfg_acsnoop);
    assign w_addr_ok  = !cfg_addrflt_en ||
                        ((acaddr >= w_base_ext) && ({1'b0, acaddr} < w_limit));
    assign w_match    = cfg_en & w_snoop_ok & w_addr_ok;

    assign w_in_entry.addr  = acaddr;
    assign w_in_entry.snoop = acsnoop;
    assign w_in_entry.prot  = acprot;
    assign w_in_entry.match = w_match;

    ace_skid_buf u_skid_buf (
        .i_clk   (ace_aclk),
        .i_rst_n (ace_aresetn),
        .i_valid (acvalid),
        .o_ready (acready),
        .i_data  (w_in_entry),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_data  (w_out_entry)
    );

    assign m_addr  = w_out_entry.addr;
    assign m_snoop = w_out_entry.snoop;
    assign m_prot  = w_out_entry.prot;
    assign m_match = w_out_entry.match;

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            r_snoop_cnt <= '0;
            r_match_cnt <= '0;
        end else if (stat_clr) begin
            r_snoop_cnt <= '0;
            r_match_cnt <= '0;
        end else if (w_ac_hs) begin
            if (r_snoop_cnt != '1) begin
                r_snoop_cnt <= r_snoop_cnt + CNT_W'(1);
            end
            if (w_match && (r_match_cnt != '1)) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
        end
    end

    assign stat_snoop_cnt = r_snoop_cnt;
    assign stat_match_cnt = r_match_cnt;

endmodule

// File: tb/tb_ace_ac_ingress.sv
// Directed bench for ace_ac_ingress. Counters are built 4 bits wide so saturation is
// reachable in a handful of snoops.
module tb_ace_ac_ingress;
    import devil_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic               ace_aclk = 1'b0;
    logic               ace_aresetn;
    logic               acvalid;
    logic               acready;
    logic [ADDR_W-1:0]  acaddr;
    logic [SNOOP_W-1:0] acsnoop;
    logic [2:0]         acprot;
    logic               cfg_en;
    logic               cfg_acflt_en;
    logic               cfg_addrflt_en;
    logic [SNOOP_W-1:0] cfg_acsnoop;
    logic [31:0]        cfg_base_addr;
    logic [31:0]        cfg_mem_size;
    logic               stat_clr;
    logic               m_valid;
    logic               m_ready;
    logic [ADDR_W-1:0]  m_addr;
    logic [SNOOP_W-1:0] m_snoop;
    logic [2:0]         m_prot;
    logic               m_match;
    logic [CNT_W-1:0]   stat_snoop_cnt;
    logic [CNT_W-1:0]   stat_match_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ace_aclk = ~ace_aclk;

    ace_ac_ingress #(
        .CNT_W (CNT_W)
    ) dut (
        .ace_aclk       (ace_aclk),
        .ace_aresetn    (ace_aresetn),
        .acvalid        (acvalid),
        .acready        (acready),
        .acaddr         (acaddr),
        .acsnoop        (acsnoop),
        .acprot         (acprot),
        .cfg_en         (cfg_en),
        .cfg_acflt_en   (cfg_acflt_en),
        .cfg_addrflt_en (cfg_addrflt_en),
        .cfg_acsnoop    (cfg_acsnoop),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_mem_size   (cfg_mem_size),
        .stat_clr       (stat_clr),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_addr         (m_addr),
        .m_snoop        (m_snoop),
        .m_prot         (m_prot),
        .m_match        (m_match),
        .stat_snoop_cnt (stat_snoop_cnt),
        .stat_match_cnt (stat_match_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ace_aclk);
        #1;
    endtask

    // Presents one snoop, waits (bounded) for acready, completes the handshake edge and
    // returns #1 after it with acvalid dropped.
    task automatic send(input logic [ADDR_W-1:0] a, input logic [SNOOP_W-1:0] s,
                        input logic [2:0] p);
        int n;
        n = 0;
        acvalid = 1'b1;
        acaddr  = a;
        acsnoop = s;
        acprot  = p;
        while (!acready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check_eq("send_acready_timeout", {63'd0, acready}, 64'd1);
        tick();
        acvalid = 1'b0;
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int sn, input int mt);
        check_eq({tag, "_snoop_cnt"}, 64'(stat_snoop_cnt), 64'(sn));
        check_eq({tag, "_match_cnt"}, 64'(stat_match_cnt), 64'(mt));
    endtask

    // Address-window vectors: address, expected match.
    logic [ADDR_W-1:0] win_addr [4] = '{44'hF, 44'h10, 44'h10F, 44'h110};
    logic              win_exp  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ace_aresetn    = 1'b0;
        acvalid        = 1'b0;
        acaddr         = '0;
        acsnoop        = '0;
        acprot         = '0;
        cfg_en         = 1'b1;
        cfg_acflt_en   = 1'b0;
        cfg_addrflt_en = 1'b0;
        cfg_acsnoop    = '0;
        cfg_base_addr  = '0;
        cfg_mem_size   = '0;
        stat_clr       = 1'b0;
        m_ready        = 1'b1;

        // Reset
        repeat (16) tick();
        check_eq("rst_acready", {63'd0, acready}, 64'd0);
        check_eq("rst_m_valid", {63'd0, m_valid}, 64'd0);
        check_eq("rst_m_addr", 64'(m_addr), 64'd0);
        check_eq("rst_m_match", {63'd0, m_match}, 64'd0);
        check_counts("rst", 0, 0);
        ace_aresetn = 1'b1;
        tick();
        check_eq("rst_release_acready", {63'd0, acready}, 64'd1);

        // Filters off, single snoop
        send(44'h2, AcsnoopReadOnce, 3'b101);
        check_eq("basic_m_valid", {63'd0, m_valid}, 64'd1);
        check_eq("basic_m_addr", 64'(m_addr), 64'h2);
        check_eq("basic_m_prot", 64'(m_prot), 64'h5);
        check_eq("basic_m_match", {63'd0, m_match}, 64'd1);
        check_counts("basic", 1, 1);
        tick();
        check_eq("basic_drained", {63'd0, m_valid}, 64'd0);

        // ACSNOOP filter
        clear_stats();
        check_counts("clr", 0, 0);
        cfg_acflt_en = 1'b1;
        cfg_acsnoop  = 4'd1;
        send(44'h40, 4'd0, 3'b000);
        check_eq("acflt_snoop0_match", {63'd0, m_match}, 64'd0);
        check_eq("acflt_snoop0_snoop", 64'(m_snoop), 64'd0);
        send(44'h40, 4'd1, 3'b000);
        check_eq("acflt_snoop1_match", {63'd0, m_match}, 64'd1);
        check_eq("acflt_snoop1_snoop", 64'(m_snoop), 64'd1);
        check_counts("acflt", 2, 1);
        cfg_acflt_en = 1'b0;

        // Address window
        clear_stats();
        cfg_addrflt_en = 1'b1;
        cfg_base_addr  = 32'h10;
        cfg_mem_size   = 32'h100;
        for (int i = 0; i < 4; i++) begin
            send(win_addr[i], 4'd0, 3'b000);
            check_eq($sformatf("win_0x%0h_addr", win_addr[i]), 64'(m_addr), 64'(win_addr[i]));
            check_eq($sformatf("win_0x%0h_match", win_addr[i]), {63'd0, m_match},
                     {63'd0, win_exp[i]});
        end
        cfg_mem_size = 32'h0;
        send(44'h10, 4'd0, 3'b000);
        check_eq("win_size0_match", {63'd0, m_match}, 64'd0);
        check_counts("win", 5, 2);

        // Window ending above 2^32 must not wrap
        cfg_base_addr = 32'hFFFF_FFF0;
        cfg_mem_size  = 32'h20;
        send(44'h1_0000_0005, 4'd0, 3'b000);
        check_eq("win_hi_in_match", {63'd0, m_match}, 64'd1);
        send(44'h1_0000_0010, 4'd0, 3'b000);
        check_eq("win_hi_end_match", {63'd0, m_match}, 64'd0);
        cfg_addrflt_en = 1'b0;

        // Disabled: forwarded, never matched
        cfg_en = 1'b0;
        send(44'h80, 4'd0, 3'b000);
        check_eq("dis_m_valid", {63'd0, m_valid}, 64'd1);
        check_eq("dis_m_match", {63'd0, m_match}, 64'd0);
        cfg_en = 1'b1;
        tick();
        tick();

        // Backpressure: fill, hold, drain in order; third snoop taken after cfg_en drops
        clear_stats();
        m_ready = 1'b0;
        acvalid = 1'b1;
        acaddr  = 44'h100;
        tick();
        check_eq("bp_first_valid", {63'd0, m_valid}, 64'd1);
        check_eq("bp_first_addr", 64'(m_addr), 64'h100);
        acaddr = 44'h200;
        tick();
        check_eq("bp_full_acready", {63'd0, acready}, 64'd0);
        check_eq("bp_full_addr", 64'(m_addr), 64'h100);
        cfg_en = 1'b0;
        acaddr = 44'h300;
        tick();
        check_eq("bp_hold_acready", {63'd0, acready}, 64'd0);
        check_eq("bp_hold_valid", {63'd0, m_valid}, 64'd1);
        check_eq("bp_hold_addr", 64'(m_addr), 64'h100);
        check_eq("bp_hold_match", {63'd0, m_match}, 64'd1);
        check_counts("bp_hold", 2, 2);
        m_ready = 1'b1;
        tick();
        check_eq("bp_drain2_addr", 64'(m_addr), 64'h200);
        check_eq("bp_drain2_match", {63'd0, m_match}, 64'd1);
        check_eq("bp_drain2_acready", {63'd0, acready}, 64'd1);
        tick();
        acvalid = 1'b0;
        check_eq("bp_drain3_addr", 64'(m_addr), 64'h300);
        check_eq("bp_drain3_match", {63'd0, m_match}, 64'd0);
        check_counts("bp", 3, 2);
        tick();
        check_eq("bp_empty", {63'd0, m_valid}, 64'd0);
        cfg_en = 1'b1;

        // Saturation at 4'hF, then clear beats a simultaneous handshake
        clear_stats();
        for (int i = 0; i < 17; i++) send(44'(i), 4'd0, 3'b000);
        check_counts("sat", 15, 15);
        stat_clr = 1'b1;
        acvalid  = 1'b1;
        acaddr   = 44'h55;
        check_eq("clr_hs_acready", {63'd0, acready}, 64'd1);
        tick();
        stat_clr = 1'b0;
        acvalid  = 1'b0;
        check_counts("clr_hs", 0, 0);
        tick();

        // Reset while FULL
        m_ready = 1'b0;
        send(44'hA0, 4'd0, 3'b000);
        send(44'hB0, 4'd0, 3'b000);
        check_eq("rstfull_acready", {63'd0, acready}, 64'd0);
        check_eq("rstfull_addr", 64'(m_addr), 64'hA0);
        #2;
        ace_aresetn = 1'b0;
        #1;
        check_eq("rstfull_async_valid", {63'd0, m_valid}, 64'd0);
        check_eq("rstfull_async_addr", 64'(m_addr), 64'd0);
        check_counts("rstfull_async", 0, 0);
        tick();
        ace_aresetn = 1'b1;
        m_ready     = 1'b1;
        tick();
        check_eq("rstfull_after_valid", {63'd0, m_valid}, 64'd0);
        check_eq("rstfull_after_acready", {63'd0, acready}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
